uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmit engine (8N1, byte-wide parallel load) among NREQ byte sources.
//  Performs round-robin arbitration and a per-requester valid/ready handshake.
//  Sequences each byte as start-pulse -> wait-for-done -> inter-byte gap, with a watchdog.
//  Sits between requesters (switch/debug/status sources) and the UART TX engine in the top level.
// PARAMETERS
//  NREQ          4      number of requesters (2..8)
//  TIMEOUT_CLKS  20000  max clocks from tx_start to tx_done before abort (>= 10*868 for 115200 baud)
//  GAP_CLKS      868    idle clocks inserted after each byte; 0 = no gap
// PORTS
//  clk          in   1         system clock, all logic on rising edge
//  rst_n        in   1         asynchronous active-low reset
//  arb_en       in   1         1 = new grants allowed; 0 = finish current byte, then hold in IDLE
//  req_valid    in   NREQ      bit i: requester i has a byte pending
//  req_data     in   8*NREQ    byte of requester i on [8*i+7:8*i]
//  req_ready    out  NREQ      one-cycle pulse: byte of requester i accepted
//  tx_start     out  1         one-cycle pulse to UART TX engine: load tx_data and send
//  tx_data      out  8         byte to send; held stable from tx_start until leaving WAIT
//  tx_done      in   1         one-cycle pulse from UART TX engine: stop bit finished
//  grant_id     out  clog2(NREQ)  index of requester currently/last served
//  busy         out  1         1 whenever state != IDLE
//  err_timeout  out  1         sticky: a byte timed out
//  err_clr      in   1         synchronous clear of err_timeout
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; req_ready=0, tx_start=0, tx_data=0, grant_id=0, busy=0,
//   err_timeout=0; counters=0; round-robin pointer last=NREQ-1 (requester 0 has top priority).
//   Reset mid-byte abandons the transfer; no tx_start is reissued afterwards.
//  States: IDLE, ISSUE, WAIT, GAP. All outputs registered.
//  IDLE: if arb_en && |req_valid: winner w = first set bit searching last+1, last+2, ... (mod NREQ);
//   capture req_data[w] into tx_data, grant_id<=w, last<=w, go ISSUE. Otherwise stay.
//  ISSUE (exactly 1 cycle): tx_start=1, req_ready[w]=1; cnt<=0; go WAIT.
//   Acceptance latency: data sampled on edge ending the IDLE cycle; ready/start appear 1 cycle later.
//   Requester must hold valid/data until it sees req_ready; next byte may be presented the cycle after.
//  WAIT: cnt increments each cycle. tx_done=1 -> go GAP (cnt<=0). Else cnt==TIMEOUT_CLKS-1 ->
//   err_timeout<=1, go GAP. tx_done and timeout in the same cycle: done wins, no error.
//   tx_done seen in IDLE/ISSUE/GAP is ignored.
//  GAP: count GAP_CLKS cycles then go IDLE; GAP_CLKS=0 -> IDLE on the next cycle.
//   Minimum byte-to-byte spacing: tx_start pulses >= (done latency + GAP_CLKS + 2) apart.
//  arb_en=0 never aborts WAIT/GAP; only blocks the IDLE->ISSUE transition.
//  err_clr=1 clears err_timeout; a simultaneous timeout set takes priority (flag stays 1).
//  Requester dropping req_valid in IDLE before being granted: no grant, no ready.
//  Counter widths: clog2(max(TIMEOUT_CLKS, GAP_CLKS)+1); no wrap within valid parameter range.
//  Round-robin guarantees each continuously-valid requester is served within NREQ grants.
// TESTING
//  1 Reset, req_valid=4'b0001, data0=8'hA5, tx_done 8680 clks after start -> tx_start once, tx_data=A5,
//    req_ready=0001 one cycle, busy falls GAP_CLKS+1 clks after done, err_timeout=0.
//  2 All 4 valid continuously (data 8'h10,11,12,13) -> grant order 0,1,2,3,0 ; tx_data matches each.
//  3 Never pulse tx_done -> err_timeout=1 after exactly TIMEOUT_CLKS clks in WAIT; FSM returns to IDLE;
//    err_clr pulse -> err_timeout=0.
//  4 tx_done on the same cycle as cnt==TIMEOUT_CLKS-1 -> err_timeout stays 0.
//  5 arb_en=0 mid-WAIT with requester 2 valid -> current byte completes; no new tx_start until arb_en=1.
//  6 rst_n low for 3 clks mid-WAIT -> all outputs 0 immediately (async); after release requester 0
//    granted first; GAP_CLKS=0 build: back-to-back bytes 2 clks after each tx_done.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one 8N1 UART transmit engine among NREQ byte sources.
// Each grant sequences start pulse -> wait for done (with watchdog) -> optional idle gap.
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int TIMEOUT_CLKS = 20000,
    parameter int GAP_CLKS     = 868
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      arb_en,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [8*NREQ-1:0]         req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      tx_start,
    output logic [7:0]                tx_data,
    input  logic                      tx_done,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy,
    output logic                      err_timeout,
    input  logic                      err_clr
);

    localparam int GW         = $clog2(NREQ);
    localparam int CNT_MAX    = (TIMEOUT_CLKS > GAP_CLKS) ? TIMEOUT_CLKS : GAP_CLKS;
    localparam int CW         = $clog2(CNT_MAX + 1);
    localparam int GAP_LAST_I = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CLKS - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LAST_I);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [GW-1:0]     last_reg, last_next;
    logic [GW-1:0]     grant_reg, grant_next;
    logic [7:0]        tx_data_reg, tx_data_next;
    logic [NREQ-1:0]   req_ready_reg, req_ready_next;
    logic              tx_start_reg, tx_start_next;
    logic              busy_reg, busy_next;
    logic              err_reg, err_next;

    logic [7:0]        req_bytes [NREQ];
    logic              win_found;
    logic [GW-1:0]     win_idx;
    logic [GW-1:0]     cand;
    logic              wait_end;
    logic              timeout_hit;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_bytes[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Rotating priority: the search starts just after the last served requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last_reg) + k) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Done wins over a coincident watchdog expiry.
    assign wait_end    = tx_done || (cnt_reg == TO_LAST);
    assign timeout_hit = (state_reg == S_WAIT) && !tx_done && (cnt_reg == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            last_reg      <= GW'(NREQ - 1);
            grant_reg     <= '0;
            tx_data_reg   <= '0;
            req_ready_reg <= '0;
            tx_start_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            last_reg      <= last_next;
            grant_reg     <= grant_next;
            tx_data_reg   <= tx_data_next;
            req_ready_reg <= req_ready_next;
            tx_start_reg  <= tx_start_next;
            busy_reg      <= busy_next;
            err_reg       <= err_next;
        end
    end

    // With no gap configured the engine returns straight to IDLE after a byte.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (arb_en && win_found) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (wait_end) begin
                    state_next = (GAP_CLKS > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_next       = cnt_reg;
        last_next      = last_reg;
        grant_next     = grant_reg;
        tx_data_next   = tx_data_reg;
        req_ready_next = '0;
        tx_start_next  = 1'b0;
        busy_next      = (state_next != S_IDLE);
        case (state_reg)
            S_IDLE: begin
                if (state_next == S_ISSUE) begin
                    tx_data_next            = req_bytes[win_idx];
                    grant_next              = win_idx;
                    last_next               = win_idx;
                    tx_start_next           = 1'b1;
                    req_ready_next[win_idx] = 1'b1;
                end
            end
            S_ISSUE: begin
                cnt_next = '0;
            end
            S_WAIT: begin
                if (wait_end) begin
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                cnt_next = '0;
            end
        endcase

        // A timeout in the same cycle as a clear leaves the flag set.
        if (timeout_hit) begin
            err_next = 1'b1;
        end else if (err_clr) begin
            err_next = 1'b0;
        end else begin
            err_next = err_reg;
        end
    end

    assign req_ready   = req_ready_reg;
    assign tx_start    = tx_start_reg;
    assign tx_data     = tx_data_reg;
    assign grant_id    = grant_reg;
    assign busy        = busy_reg;
    assign err_timeout = err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scoreboard of expected grants checked by a monitor thread,
// plus timing checks on busy, the watchdog flag and reset; a second instance runs with no gap.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int TO   = 40;
    localparam int GAP  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              arb_en;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_done = 1'b0;
    logic [1:0]        grant_id;
    logic              busy;
    logic              err_timeout;
    logic              err_clr;

    logic [NREQ-1:0]   rv0;
    logic [8*NREQ-1:0] rd0;
    logic [NREQ-1:0]   ready0;
    logic              start0;
    logic [7:0]        data0;
    logic              done0;
    logic [1:0]        grant0;
    logic              busy0;
    logic              err0;

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT_CLKS(TO), .GAP_CLKS(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT_CLKS(TO), .GAP_CLKS(0)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req_valid(rv0), .req_data(rd0),
        .req_ready(ready0), .tx_start(start0), .tx_data(data0), .tx_done(done0),
        .grant_id(grant0), .busy(busy0), .err_timeout(err0), .err_clr(1'b0)
    );

    typedef struct packed {
        logic [1:0] g;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp0_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   done_en = 1'b1;
    int   done_lat = 3;
    bit   hold_valid = 1'b0;
    int   n, m, c, starts;

    // TX engine model: pulses tx_done so it is sampled at the end of WAIT cycle done_lat.
    always begin
        @(negedge clk);
        if (tx_start && done_en) begin
            repeat (done_lat) @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (tx_start) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_start", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant_id", 32'(grant_id), 32'(e.g));
                        chk("tx_data", 32'(tx_data), 32'(e.d));
                        chk("req_ready", 32'(req_ready), 32'(1) << e.g);
                        $display("txn main: grant=%0d data=%02h ready=%b", grant_id, tx_data, req_ready);
                    end
                end else if (req_ready != '0) begin
                    chk("ready_without_start", 32'(req_ready), 32'd0);
                end
                if (start0) begin
                    if (exp0_q.size() == 0) begin
                        chk("g0_unexpected_start", 32'd1, 32'd0);
                    end else begin
                        e = exp0_q.pop_front();
                        chk("g0_grant_id", 32'(grant0), 32'(e.g));
                        chk("g0_tx_data", 32'(data0), 32'(e.d));
                        chk("g0_req_ready", 32'(ready0), 32'(1) << e.g);
                        $display("txn gap0: grant=%0d data=%02h ready=%b", grant0, data0, ready0);
                    end
                end
            end
        end
    endtask

    // Requesters drop valid once they see their ready pulse.
    task automatic tick();
        @(negedge clk);
        if (!hold_valid) req_valid = req_valid & ~req_ready;
        rv0 = rv0 & ~ready0;
    endtask

    task automatic wait_start(input string name, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!tx_start && cnt < 500);
        chk(name, 32'(tx_start), 32'd1);
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (busy && cnt < 500);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    function automatic exp_t mk(input logic [1:0] g, input logic [7:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        return e;
    endfunction

    initial begin
        rst_n = 1'b0; arb_en = 1'b1; err_clr = 1'b0;
        req_valid = '0; req_data = '0;
        rv0 = '0; rd0 = {8'h00, 8'h00, 8'hC1, 8'hC0}; done0 = 1'b0;
        fork
            monitor_loop();
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_timeout), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single byte from requester 0
        done_lat = 30;
        req_data = {8'h00, 8'h00, 8'h00, 8'hA5};
        req_valid = 4'b0001;
        exp_q.push_back(mk(2'd0, 8'hA5));
        wait_start("t1_start", n);
        chk("t1_latency", n, 1);
        wait_idle(m);
        chk("t1_busy_fall", m, done_lat + GAP + 1);
        chk("t1_err", 32'(err_timeout), 0);

        // 2: all requesters continuously valid
        do_reset();
        done_lat = 3;
        hold_valid = 1'b1;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b1111;
        exp_q.push_back(mk(2'd0, 8'h10));
        exp_q.push_back(mk(2'd1, 8'h11));
        exp_q.push_back(mk(2'd2, 8'h12));
        exp_q.push_back(mk(2'd3, 8'h13));
        exp_q.push_back(mk(2'd0, 8'h10));
        for (int i = 0; i < 5; i++) begin
            wait_start("t2_start", n);
            if (i == 0) chk("t2_first_latency", n, 1);
            else        chk("t2_spacing", n, done_lat + GAP + 2);
        end
        req_valid = '0;
        hold_valid = 1'b0;
        wait_idle(m);

        // 3: watchdog expiry, sticky flag, clear
        done_en = 1'b0;
        req_data = {8'h00, 8'h00, 8'h3C, 8'h00};
        req_valid = 4'b0010;
        exp_q.push_back(mk(2'd1, 8'h3C));
        wait_start("t3_start", n);
        repeat (TO) tick();
        chk("t3_err_before", 32'(err_timeout), 0);
        chk("t3_busy_wait", 32'(busy), 1);
        tick();
        chk("t3_err_set", 32'(err_timeout), 1);
        wait_idle(m);
        chk("t3_gap_after_timeout", m, GAP);
        chk("t3_err_sticky", 32'(err_timeout), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_err_clr", 32'(err_timeout), 0);

        // 3b: timeout set beats a simultaneous clear
        err_clr = 1'b1;
        req_data = {8'h00, 8'h5A, 8'h00, 8'h00};
        req_valid = 4'b0100;
        exp_q.push_back(mk(2'd2, 8'h5A));
        wait_start("t3b_start", n);
        repeat (TO) tick();
        chk("t3b_err_before", 32'(err_timeout), 0);
        tick();
        chk("t3b_set_beats_clr", 32'(err_timeout), 1);
        tick();
        chk("t3b_clr_after", 32'(err_timeout), 0);
        err_clr = 1'b0;
        wait_idle(m);

        // 4: done coincides with last watchdog cycle
        done_en = 1'b1;
        done_lat = TO;
        req_data = {8'h7E, 8'h00, 8'h00, 8'h00};
        req_valid = 4'b1000;
        exp_q.push_back(mk(2'd3, 8'h7E));
        wait_start("t4_start", n);
        wait_idle(m);
        chk("t4_busy_fall", m, TO + GAP + 1);
        chk("t4_no_err", 32'(err_timeout), 0);

        // 5: arb_en dropped mid-WAIT
        done_lat = 20;
        req_data = {8'h00, 8'h22, 8'h00, 8'h11};
        req_valid = 4'b0001;
        exp_q.push_back(mk(2'd0, 8'h11));
        wait_start("t5_start", n);
        req_valid = req_valid | 4'b0100;
        repeat (5) tick();
        arb_en = 1'b0;
        wait_idle(m);
        chk("t5_byte_completes", m, done_lat + GAP + 1 - 5);
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_start) starts++;
        end
        chk("t5_no_start_while_disabled", starts, 0);
        chk("t5_idle_while_disabled", 32'(busy), 0);
        exp_q.push_back(mk(2'd2, 8'h22));
        arb_en = 1'b1;
        wait_start("t5_resume_start", n);
        chk("t5_resume_latency", n, 1);
        wait_idle(m);

        // 6: reset mid-WAIT, then requester 0 wins first
        done_en = 1'b0;
        req_data = {8'h03, 8'h00, 8'h99, 8'h01};
        req_valid = 4'b0010;
        exp_q.push_back(mk(2'd1, 8'h99));
        wait_start("t6_start", n);
        repeat (3) tick();
        chk("t6_busy_before_reset", 32'(busy), 1);
        req_valid = 4'b1001;
        rst_n = 1'b0;
        #1;
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_tx_data", 32'(tx_data), 0);
        chk("t6_async_grant", 32'(grant_id), 0);
        chk("t6_async_start", 32'(tx_start), 0);
        chk("t6_async_ready", 32'(req_ready), 0);
        repeat (3) tick();
        done_en = 1'b1;
        done_lat = 3;
        exp_q.push_back(mk(2'd0, 8'h01));
        exp_q.push_back(mk(2'd3, 8'h03));
        rst_n = 1'b1;
        wait_start("t6_post_start0", n);
        chk("t6_post_latency", n, 1);
        wait_start("t6_post_start1", n);
        chk("t6_post_spacing", n, done_lat + GAP + 2);
        wait_idle(m);
        chk("t6_post_busy_fall", m, done_lat + GAP + 1);

        // 6b: zero-gap instance, back-to-back bytes
        rv0 = 4'b0011;
        exp0_q.push_back(mk(2'd0, 8'hC0));
        exp0_q.push_back(mk(2'd1, 8'hC1));
        c = 0;
        do begin
            tick();
            c++;
        end while (!start0 && c < 50);
        chk("g0_first_latency", c, 1);
        repeat (4) tick();
        c = 0;
        done0 = 1'b1;
        do begin
            tick();
            c++;
            done0 = 1'b0;
        end while (!start0 && c < 50);
        chk("g0_b2b_spacing", c, 2);
        repeat (3) tick();
        chk("g0_busy_wait", 32'(busy0), 1);
        done0 = 1'b1;
        tick();
        done0 = 1'b0;
        chk("g0_busy_fall", 32'(busy0), 0);

        repeat (3) tick();
        chk("sb_drained", exp_q.size(), 0);
        chk("g0_sb_drained", exp0_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
